// File: rtl/crc_stream_gen.sv
// crc_stream_gen
//   Serial CRC generator/appender sitting between the bit-stream encoder and
//   the bit stuffer. Each packet passes HDR_BITS uncovered header bits, then
//   (token) a CRCA_W-bit CRC or (data) a CRCB_W-bit CRC over the body, or
//   (handshake) no CRC. The complemented CRC is appended MSB-first. All bits
//   pass through a FIFO_DEPTH-bit FIFO so bit-stuffer pauses never drop data.
//
//   Optional build macro CRC_ERR_INJECT_EN: adds input inj_err, sampled when
//   the FSM enters APPEND; when set, the last appended CRC bit is inverted.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   pkt_in[1:0]  packet type sampled in IDLE: 01 token, 11 data, 10 handshake
//   s_in/s_valid input bit stream; a bit is taken when s_valid & s_ready
//   endr         marks the accepted bit as the last raw bit of the packet
//   s_ready      FIFO not full and FSM in HDR/BODY
//   pause        bit-stuffer stall, blocks FIFO reads
//   s_out        FIFO head bit
//   s_out_valid  s_out is consumed this cycle
//   start_b      one-cycle pulse when packet output begins
//   endb         one-cycle pulse after the last packet bit left the FIFO
//   err          one-cycle pulse: endr inside the header of a token/data packet
module crc_stream_gen #(
   parameter int                FIFO_DEPTH   = 32,
   parameter int                HDR_BITS     = 16,
   parameter int                START_THRESH = 16,
   parameter int                CRCA_W       = 5,
   parameter logic [CRCA_W-1:0] CRCA_POLY    = 5'h05,
   parameter int                CRCB_W       = 16,
   parameter logic [CRCB_W-1:0] CRCB_POLY    = 16'h8005
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] pkt_in,
   input  logic       s_in,
   input  logic       s_valid,
   input  logic       endr,
   output logic       s_ready,
   input  logic       pause,
`ifdef CRC_ERR_INJECT_EN
   input  logic       inj_err,
`endif
   output logic       s_out,
   output logic       s_out_valid,
   output logic       start_b,
   output logic       endb,
   output logic       err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HDR_BITS + 1);
   // append index must cover the wider of the two CRCs
   localparam int IW = $clog2(((CRCB_W > CRCA_W) ? CRCB_W : CRCA_W) + 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_APPEND, S_DRAIN} state_t;

   state_t              state;
   logic [1:0]          pkt_type;
   logic [HW-1:0]       hdr_cnt;
   logic [IW-1:0]       app_idx;
   logic [CRCA_W-1:0]   crc_a;
   logic [CRCB_W-1:0]   crc_b;
   logic                started;
`ifdef CRC_ERR_INJECT_EN
   logic                inj_q;
`endif

   logic [FIFO_DEPTH-1:0] mem;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;

   logic          full, empty, is_token, is_hs, hdr_last;
   logic          accept, rd, app_wr, wr, wr_bit, app_bit, enter_tail;
   logic [IW-1:0] app_last;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      full     = (count == CW'(FIFO_DEPTH));
      empty    = (count == '0);
      is_token = (pkt_type == 2'b01);
      is_hs    = (pkt_type == 2'b10);
      hdr_last = (hdr_cnt == HW'(HDR_BITS - 1));
      app_last = is_token ? IW'(CRCA_W - 1) : IW'(CRCB_W - 1);

      s_ready     = ~full & ((state == S_HDR) | (state == S_BODY));
      accept      = s_valid & s_ready;
      rd          = started & ~pause & ~empty;
      s_out_valid = rd;
      s_out       = empty ? 1'b0 : mem[rd_ptr];

      // CRC register is shifted during APPEND, so the MSB is always the next bit
      app_bit = ~(is_token ? crc_a[CRCA_W-1] : crc_b[CRCB_W-1]);
`ifdef CRC_ERR_INJECT_EN
      if (inj_q && (app_idx == app_last)) app_bit = ~app_bit;
`endif
      app_wr = (state == S_APPEND) & ~full;
      wr     = accept | app_wr;
      wr_bit = app_wr ? app_bit : s_in;

      cnt_nxt = count + CW'(wr) - CW'(rd);

      // FSM moves to APPEND or DRAIN this cycle: output must start even if
      // the FIFO never reaches START_THRESH (short packets)
      enter_tail = accept & (((state == S_HDR) & (endr | (hdr_last & is_hs))) |
                             ((state == S_BODY) & endr));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pkt_type <= 2'b00;
         hdr_cnt  <= '0;
         app_idx  <= '0;
         crc_a    <= '1;
         crc_b    <= '1;
         started  <= 1'b0;
         mem      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         start_b  <= 1'b0;
         endb     <= 1'b0;
         err      <= 1'b0;
`ifdef CRC_ERR_INJECT_EN
         inj_q    <= 1'b0;
`endif
      end else begin
         start_b <= 1'b0;
         endb    <= 1'b0;
         err     <= 1'b0;

         if (wr) begin
            mem[wr_ptr] <= wr_bit;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= cnt_nxt;

         if (~started & ((cnt_nxt >= CW'(START_THRESH)) | enter_tail)) begin
            started <= 1'b1;
            start_b <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (pkt_in != 2'b00) begin
                  pkt_type <= pkt_in;
                  crc_a    <= '1;
                  crc_b    <= '1;
                  hdr_cnt  <= '0;
                  state    <= S_HDR;
               end
            end
            S_HDR: begin
               if (accept) begin
                  hdr_cnt <= hdr_cnt + 1'b1;
                  if (is_hs) begin
                     // handshake has no body: it ends with the header
                     if (endr | hdr_last) state <= S_DRAIN;
                  end else if (endr) begin
                     err   <= 1'b1;
                     state <= S_DRAIN;
                  end else if (hdr_last) begin
                     state <= S_BODY;
                  end
               end
            end
            S_BODY: begin
               if (accept) begin
                  if (is_token)
                     crc_a <= {crc_a[CRCA_W-2:0], 1'b0} ^
                              ((s_in ^ crc_a[CRCA_W-1]) ? CRCA_POLY : '0);
                  else
                     crc_b <= {crc_b[CRCB_W-2:0], 1'b0} ^
                              ((s_in ^ crc_b[CRCB_W-1]) ? CRCB_POLY : '0);
                  if (endr) begin
                     app_idx <= '0;
                     state   <= S_APPEND;
`ifdef CRC_ERR_INJECT_EN
                     inj_q   <= inj_err;
`endif
                  end
               end
            end
            S_APPEND: begin
               if (~full) begin
                  if (is_token) crc_a <= {crc_a[CRCA_W-2:0], 1'b0};
                  else          crc_b <= {crc_b[CRCB_W-2:0], 1'b0};
                  app_idx <= app_idx + 1'b1;
                  if (app_idx == app_last) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty & started) begin
                  endb    <= 1'b1;
                  started <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
